branch_pc_ctrl: RTL
===================

// Module: branch_pc_ctrl
// PURPOSE
//  Consumer of the ALU zero flag (alu_zero = 1 when ALU result == 0). Owns the PC register of
//  the multi-cycle datapath: sequential advance, j, beq/bne resolution. A branch step waits
//  for the ALU compare result, latches the flag and redirects the PC. Sits between the control
//  FSM (step strobe, decoded op) and instruction fetch (pc output).
// PARAMETERS
//  WIDTH     32            PC / address width
//  RESET_PC  32'h0000_0000 PC value after reset
//  CNT_W     16            width of saturating taken-branch counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  step       in   1      one-cycle strobe: retire current instruction, compute next PC
//  op_beq     in   1      decoded beq (sampled with step)
//  op_bne     in   1      decoded bne (sampled with step)
//  op_j       in   1      decoded j (sampled with step)
//  imm16      in   16     branch offset, in words, signed (sampled with step)
//  jaddr      in   26     jump target field (sampled with step)
//  alu_valid  in   1      ALU compare result valid this cycle
//  alu_zero   in   1      zero flag from ALU, meaningful only with alu_valid
//  pc         out  WIDTH  current PC (registered)
//  pc_plus4   out  WIDTH  pc + 4, combinational, wraps mod 2^WIDTH
//  busy       out  1      1 while in WAIT_ALU
//  taken      out  1      one-cycle pulse, registered, coincident with redirected pc
//  taken_cnt  out  CNT_W  count of taken branches/jumps, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, busy=0, taken=0, taken_cnt=0, latches cleared.
//  States: IDLE, WAIT_ALU.
//  IDLE, step=0: hold pc.
//  IDLE, step=1, op priority j > beq > bne > sequential (multiple ops asserted: highest wins):
//   - sequential: pc <= pc_plus4 at that edge; taken=0.
//   - j: pc <= {pc_plus4[WIDTH-1:28], jaddr, 2'b00}; taken=1 next cycle; taken_cnt++.
//   - beq/bne: latch op, target = pc_plus4 + (sext(imm16) << 2) (mod 2^WIDTH); go WAIT_ALU; pc held.
//  WAIT_ALU: alu_valid sampled only here (alu_valid in IDLE ignored, incl. same cycle as step).
//   - alu_valid=0: stay, busy=1.
//   - alu_valid=1: cond = beq ? alu_zero : ~alu_zero. cond: pc <= target, taken pulse, taken_cnt++;
//     else pc <= latched pc_plus4. Return to IDLE at same edge.
//  Latency: seq/j 1 cycle (step edge); branch: pc changes on edge where alu_valid seen in WAIT_ALU,
//   minimum 2 cycles after step.
//  step while busy: ignored (no relatch, no error); control FSM must not issue it.
//  Wrap: pc=FFFF_FFFC sequential -> 0000_0000; branch target arithmetic wraps silently.
//  taken_cnt at all-ones: holds; taken still pulses.
//  rst_n asserted in WAIT_ALU: immediate return to reset state; pending branch discarded.
//  No combinational path from inputs to pc/taken/busy; pc_plus4 depends on pc only.
// STRUCTURE
//  Shared package: state encoding (IDLE=1'b0, WAIT_ALU=1'b1), op-priority encoding,
//   RESET_PC default, WORD_SHIFT=2 constant.
//  Sub-module: branch_target_gen (combinational: pc_plus4, sext offset add, jump concat);
//   FSM, PC register, counter stay in top.
// TESTING
//  1 Reset: rst_n low mid-cycle -> pc=0, busy=0, taken=0, taken_cnt=0 without clock edge.
//  2 Sequential: pc=0x100, step, no op -> pc=0x104 next edge, taken stays 0.
//  3 beq taken: pc=0x100, imm16=0xFFFE, step; 3 idle cycles; alu_valid=1, alu_zero=1
//    -> busy=1 for 4 cycles, pc=0x0FC, taken one pulse, taken_cnt=1.
//  4 bne not taken: pc=0x200, imm16=0x0010, alu_zero=1 -> pc=0x204, taken=0, cnt unchanged.
//  5 j + priority: pc=0x9000_0000, op_j=op_beq=1, jaddr=0x0000040 -> pc=0x9000_0100, no WAIT_ALU.
//  6 Corners: pc=FFFF_FFFC step -> 0; step during WAIT_ALU ignored; rst_n low in WAIT_ALU
//    -> IDLE, pc=RESET_PC; taken_cnt preset to FFFF + taken branch -> stays FFFF.

Source files
------------

// File: rtl/branch_pc_ctrl_pkg.sv
// ============================================================================
// Module : branch_pc_ctrl_pkg
// Brief  : Shared constants, state encoding and op-priority decode for the PC controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package branch_pc_ctrl_pkg;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ALU = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          WORD_SHIFT       = 2;

    typedef enum logic [1:0] {
        OP_SEQ = 2'd0,
        OP_J   = 2'd1,
        OP_BEQ = 2'd2,
        OP_BNE = 2'd3
    } op_sel_e;

    // Several decoded ops at once resolve as j > beq > bne > sequential.
    function automatic op_sel_e op_select(input logic op_j,
                                          input logic op_beq,
                                          input logic op_bne);
        op_sel_e sel;
        if (op_j)        sel = OP_J;
        else if (op_beq) sel = OP_BEQ;
        else if (op_bne) sel = OP_BNE;
        else             sel = OP_SEQ;
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_pc_ctrl_target_gen.sv
// ============================================================================
// Module : branch_target_gen
// Brief  : Combinational next-PC candidates: pc+4, branch target, jump target.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_target_gen
    import branch_pc_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jaddr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] j_target
);

    logic [WIDTH-1:0] w_offset;
    logic [27:0]      w_j_low;

    assign pc_plus4  = pc + WIDTH'(4);
    assign w_offset  = WIDTH'($signed(imm16)) << WORD_SHIFT;
    assign br_target = pc_plus4 + w_offset;
    assign w_j_low   = {jaddr, 2'b00};

    // The jump keeps the 256 MiB region of the following instruction.
    if (WIDTH > 28) begin : g_j_region
        assign j_target = {pc_plus4[WIDTH-1:28], w_j_low};
    end else begin : g_j_narrow
        assign j_target = w_j_low[WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/branch_pc_ctrl.sv
// ============================================================================
// Module : branch_pc_ctrl
// Brief  : PC register with sequential advance, j, and beq/bne resolved on the ALU zero flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_pc_ctrl
    import branch_pc_ctrl_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             op_beq,
    input  logic             op_bne,
    input  logic             op_j,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jaddr,
    input  logic             alu_valid,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             busy,
    output logic             taken,
    output logic [CNT_W-1:0] taken_cnt
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             is_beq_q, is_beq_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic [WIDTH-1:0] w_br_target;
    logic [WIDTH-1:0] w_j_target;
    op_sel_e          w_op;
    logic             w_cond;

    branch_target_gen #(
        .WIDTH (WIDTH)
    ) u_target_gen (
        .pc        (pc_q),
        .imm16     (imm16),
        .jaddr     (jaddr),
        .pc_plus4  (pc_plus4),
        .br_target (w_br_target),
        .j_target  (w_j_target)
    );

    assign w_op   = op_select(op_j, op_beq, op_bne);
    assign w_cond = is_beq_q ? alu_zero : ~alu_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            is_beq_q    <= 1'b0;
            taken_q     <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            is_beq_q    <= is_beq_d;
            taken_q     <= taken_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (step && (w_op == OP_BEQ || w_op == OP_BNE)) begin
                    state_d = ST_WAIT_ALU;
                end
            end
            ST_WAIT_ALU: begin
                if (alu_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // alu_valid only matters in WAIT_ALU; step only matters in IDLE.
    always_comb begin
        pc_d     = pc_q;
        target_d = target_q;
        is_beq_d = is_beq_q;
        taken_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step) begin
                    case (w_op)
                        OP_J: begin
                            pc_d    = w_j_target;
                            taken_d = 1'b1;
                        end
                        OP_BEQ, OP_BNE: begin
                            target_d = w_br_target;
                            is_beq_d = (w_op == OP_BEQ);
                        end
                        default: pc_d = pc_plus4;
                    endcase
                end
            end
            ST_WAIT_ALU: begin
                if (alu_valid) begin
                    if (w_cond) begin
                        pc_d    = target_q;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: pc_d = pc_q;
        endcase

        taken_cnt_d = taken_cnt_q;
        if (taken_d && !(&taken_cnt_q)) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy      = (state_q == ST_WAIT_ALU);
        pc        = pc_q;
        taken     = taken_q;
        taken_cnt = taken_cnt_q;
    end

endmodule

`default_nettype wire
